// File: rtl/fifo_rd_arb_pkg.sv
// Shared types and helpers for the FIFO read-side arbiter: state encoding,
// burst-length field width and the burst-length clamp.
package fifo_rd_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_e;

  function automatic int lenWidth(input int maxBurst);
    return $clog2(maxBurst) + 1;
  endfunction

  // A request of zero words, or of more than the cap, becomes a full-size burst.
  function automatic int clampLen(input int len, input int maxBurst);
    return (len == 0 || len > maxBurst) ? maxBurst : len;
  endfunction

endpackage

// File: rtl/fifo_rd_arbiter_rr_pick.sv
// Round-robin picker: the first set request at or after ptr_i, wrapping around.
module rr_pick #(
  parameter int NREQ = 4,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IW-1:0]   ptr_i,
  output logic [NREQ-1:0] grant_o,
  output logic [IW-1:0]   idx_o
);

  logic found;
  int   j;

  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    found   = 1'b0;
    j       = 0;
    for (int i = 0; i < NREQ; i++) begin
      j = (int'(ptr_i) + i) % NREQ;
      if (!found && req_i[IW'(j)]) begin
        found             = 1'b1;
        grant_o[IW'(j)]   = 1'b1;
        idx_o             = IW'(j);
      end
    end
  end

endmodule

// File: rtl/fifo_rd_arbiter.sv
// Read-side scheduler for the async FIFO: grants the single read port to one
// consumer at a time in round-robin bursts and steers read data to it.
module fifo_rd_arbiter
  import fifo_rd_arb_pkg::*;
#(
  parameter int NREQ      = 4,
  parameter int DSIZE     = 8,
  parameter int MAX_BURST = 8,
  parameter int LW        = lenWidth(MAX_BURST)
) (
  input  logic                 i_rclk,
  input  logic                 i_rrst_n,
  input  logic [NREQ-1:0]      i_req,
  input  logic [NREQ*LW-1:0]   i_len,
  input  logic [NREQ-1:0]      i_rd_ready,
  input  logic                 i_rempty_flag,
  input  logic [DSIZE-1:0]     i_rdata,
  output logic                 o_r_en,
  output logic [NREQ-1:0]      o_grant,
  output logic [DSIZE-1:0]     o_rdata,
  output logic [NREQ-1:0]      o_rvalid,
  output logic [NREQ-1:0]      o_done
);

  localparam int IW = $clog2(NREQ);

  state_e            state_q, state_d;
  logic [IW-1:0]     rrPtr_q, rrPtr_d;
  logic [IW-1:0]     gIdx_q, gIdx_d;
  logic [NREQ-1:0]   grant_q, grant_d;
  logic [LW-1:0]     cnt_q, cnt_d;
  logic [LW-1:0]     len_q, len_d;
  logic [NREQ-1:0]   rvalid_q, rvalid_d;
  logic [NREQ-1:0]   done_q, done_d;
  logic [DSIZE-1:0]  rdata_q, rdata_d;

  logic [NREQ-1:0]   pickGrant;
  logic [IW-1:0]     pickIdx;
  logic [LW-1:0]     lenArr [NREQ];
  logic              inBurst;
  logic              fire;
  logic              lastWord;
  logic              term;

  for (genvar k = 0; k < NREQ; k++) begin : g_len
    assign lenArr[k] = i_len[k*LW +: LW];
  end

  rr_pick #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_rr_pick (
    .req_i   (i_req),
    .ptr_i   (rrPtr_q),
    .grant_o (pickGrant),
    .idx_o   (pickIdx)
  );

  // A read fires only for the owner, and only when it is ready and data exists.
  assign inBurst  = (state_q == BURST);
  assign fire     = inBurst & i_req[gIdx_q] & i_rd_ready[gIdx_q] & ~i_rempty_flag;
  assign lastWord = (cnt_q == len_q - LW'(1));
  assign term     = inBurst & (~i_req[gIdx_q] | (fire & lastWord));

  always_comb begin
    state_d  = state_q;
    rrPtr_d  = rrPtr_q;
    gIdx_d   = gIdx_q;
    grant_d  = grant_q;
    cnt_d    = cnt_q;
    len_d    = len_q;
    rvalid_d = '0;
    done_d   = '0;
    rdata_d  = rdata_q;
    case (state_q)
      IDLE: begin
        if (|i_req) begin
          gIdx_d  = pickIdx;
          grant_d = pickGrant;
          len_d   = LW'(clampLen(32'(lenArr[pickIdx]), MAX_BURST));
          cnt_d   = '0;
          state_d = BURST;
        end
      end
      BURST: begin
        if (fire) begin
          rvalid_d = grant_q;
          rdata_d  = i_rdata;
          cnt_d    = cnt_q + LW'(1);
        end
        if (term) begin
          done_d  = grant_q;
          cnt_d   = '0;
          rrPtr_d = IW'((int'(gIdx_q) + 1) % NREQ);
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_rclk or negedge i_rrst_n) begin
    if (!i_rrst_n) begin
      state_q  <= IDLE;
      rrPtr_q  <= '0;
      gIdx_q   <= '0;
      grant_q  <= '0;
      cnt_q    <= '0;
      len_q    <= '0;
      rvalid_q <= '0;
      done_q   <= '0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      rrPtr_q  <= rrPtr_d;
      gIdx_q   <= gIdx_d;
      grant_q  <= grant_d;
      cnt_q    <= cnt_d;
      len_q    <= len_d;
      rvalid_q <= rvalid_d;
      done_q   <= done_d;
      rdata_q  <= rdata_d;
    end
  end

  assign o_r_en   = fire;
  assign o_grant  = inBurst ? grant_q : '0;
  assign o_rdata  = rdata_q;
  assign o_rvalid = rvalid_q;
  assign o_done   = done_q;

endmodule

// File: tb/tb_fifo_rd_arbiter.sv
// Testbench for fifo_rd_arbiter: table-driven bursts, hand-written corner
// sequences and randomized traffic, all checked against a burst-level model.
module tb_fifo_rd_arbiter;

  localparam int NREQ      = 4;
  localparam int DSIZE     = 8;
  localparam int MAX_BURST = 8;
  localparam int LW        = 4;
  localparam int LENW      = NREQ * LW;

  logic                i_rclk = 1'b0;
  logic                i_rrst_n;
  logic [NREQ-1:0]     i_req;
  logic [LENW-1:0]     i_len;
  logic [NREQ-1:0]     i_rd_ready;
  logic                i_rempty_flag;
  logic [DSIZE-1:0]    i_rdata;
  logic                o_r_en;
  logic [NREQ-1:0]     o_grant;
  logic [DSIZE-1:0]    o_rdata;
  logic [NREQ-1:0]     o_rvalid;
  logic [NREQ-1:0]     o_done;

  fifo_rd_arbiter #(
    .NREQ      (NREQ),
    .DSIZE     (DSIZE),
    .MAX_BURST (MAX_BURST),
    .LW        (LW)
  ) dut (
    .i_rclk        (i_rclk),
    .i_rrst_n      (i_rrst_n),
    .i_req         (i_req),
    .i_len         (i_len),
    .i_rd_ready    (i_rd_ready),
    .i_rempty_flag (i_rempty_flag),
    .i_rdata       (i_rdata),
    .o_r_en        (o_r_en),
    .o_grant       (o_grant),
    .o_rdata       (o_rdata),
    .o_rvalid      (o_rvalid),
    .o_done        (o_done)
  );

  always #5 i_rclk = ~i_rclk;

  typedef struct {
    logic [NREQ-1:0] req;
    logic [LW-1:0]   len;
    int              words;
    logic [NREQ-1:0] expGrant;
    int              expBeats;
  } vec_t;

  vec_t tbl [8];

  int vecCount  = 0;
  int missCount = 0;

  // FIFO contents seen by the DUT, oldest word first.
  logic [DSIZE-1:0] fifoQ [$];
  logic [DSIZE-1:0] wrData = '0;

  // Burst-level reference: current owner (-1 idle), words still owed, next pointer.
  int              mOwner = -1;
  int              mLeft  = 0;
  int              mPtr   = 0;
  logic [NREQ-1:0] mValid = '0;
  logic [NREQ-1:0] mDone  = '0;
  logic [DSIZE-1:0] mData = '0;

  logic [NREQ-1:0]  lastGrant;
  logic             lastREn;
  int               beats;
  logic [NREQ-1:0]  doneSeen;
  logic [DSIZE-1:0] gotData [$];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecCount++;
    if (act !== exp) begin
      missCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic syncFifo();
    i_rempty_flag = (fifoQ.size() == 0);
    i_rdata       = (fifoQ.size() != 0) ? fifoQ[0] : '0;
  endtask

  task automatic pushWords(input int n);
    for (int i = 0; i < n; i++) begin
      fifoQ.push_back(wrData);
      wrData = wrData + 8'd1;
    end
    syncFifo();
  endtask

  task automatic doReset();
    i_rrst_n   = 1'b0;
    i_req      = '0;
    i_rd_ready = '0;
    i_len      = '0;
    fifoQ.delete();
    wrData = '0;
    syncFifo();
    mOwner = -1; mLeft = 0; mPtr = 0;
    mValid = '0; mDone = '0; mData = '0;
    #1;
    checkOutput("rst_r_en",   32'(o_r_en),   32'(0));
    checkOutput("rst_grant",  32'(o_grant),  32'(0));
    checkOutput("rst_rvalid", 32'(o_rvalid), 32'(0));
    checkOutput("rst_done",   32'(o_done),   32'(0));
    checkOutput("rst_rdata",  32'(o_rdata),  32'(0));
    @(negedge i_rclk);
    @(negedge i_rclk);
    i_rrst_n = 1'b1;
  endtask

  // One clock cycle: check the combinational outputs, advance the model and
  // the FIFO, then check the registered outputs. Starts and ends at negedge.
  task automatic applyStimulus();
    int o, idx, l;
    bit found;
    logic expREn, actREn;
    logic [NREQ-1:0] expGrant;
    #1;
    o        = mOwner;
    expREn   = (o >= 0) && i_req[o] && i_rd_ready[o] && (fifoQ.size() != 0);
    expGrant = (o >= 0) ? (4'b0001 << o) : 4'b0000;
    actREn   = o_r_en;
    lastREn  = o_r_en;
    lastGrant = o_grant;
    checkOutput("r_en",  32'(o_r_en),  32'(expREn));
    checkOutput("grant", 32'(o_grant), 32'(expGrant));

    mValid = '0;
    mDone  = '0;
    if (expREn) begin
      mValid = 4'b0001 << o;
      mData  = fifoQ[0];
    end
    if (o < 0) begin
      found = 1'b0;
      for (int k = 0; k < NREQ; k++) begin
        idx = (mPtr + k) % NREQ;
        if (!found && i_req[idx]) begin
          found  = 1'b1;
          mOwner = idx;
          l      = int'(i_len[idx*LW +: LW]);
          mLeft  = (l == 0 || l > MAX_BURST) ? MAX_BURST : l;
        end
      end
    end else begin
      if (expREn) mLeft--;
      if (!i_req[o] || (expREn && mLeft == 0)) begin
        mDone  = 4'b0001 << o;
        mPtr   = (o + 1) % NREQ;
        mOwner = -1;
      end
    end

    @(posedge i_rclk);
    #1;
    if (actREn && fifoQ.size() != 0) void'(fifoQ.pop_front());
    syncFifo();
    checkOutput("rvalid", 32'(o_rvalid), 32'(mValid));
    checkOutput("done",   32'(o_done),   32'(mDone));
    checkOutput("rdata",  32'(o_rdata),  32'(mData));
    if (o_rvalid != '0) begin
      beats++;
      gotData.push_back(o_rdata);
    end
    doneSeen = doneSeen | o_done;
    @(negedge i_rclk);
  endtask

  task automatic clearObs();
    beats    = 0;
    doneSeen = '0;
    gotData.delete();
  endtask

  initial begin
    logic [NREQ-1:0] firstGrant;
    logic [NREQ-1:0] expG;

    tbl[0] = '{4'b0010, 4'd4,  10, 4'b0010, 4};
    tbl[1] = '{4'b0001, 4'd1,  3,  4'b0001, 1};
    tbl[2] = '{4'b1000, 4'd0,  10, 4'b1000, 8};
    tbl[3] = '{4'b0100, 4'd15, 12, 4'b0100, 8};
    tbl[4] = '{4'b1100, 4'd8,  8,  4'b0100, 8};
    tbl[5] = '{4'b1010, 4'd2,  4,  4'b0010, 2};
    tbl[6] = '{4'b1111, 4'd3,  5,  4'b0001, 3};
    tbl[7] = '{4'b0101, 4'd9,  9,  4'b0001, 8};

    i_rrst_n = 1'b0;
    @(negedge i_rclk);

    // Single bursts straight out of reset.
    for (int v = 0; v < 8; v++) begin
      doReset();
      pushWords(tbl[v].words);
      i_len      = {NREQ{tbl[v].len}};
      i_rd_ready = '1;
      i_req      = tbl[v].req;
      clearObs();
      firstGrant = '0;
      for (int c = 0; c < 40 && doneSeen == '0; c++) begin
        applyStimulus();
        if (firstGrant == '0) firstGrant = lastGrant;
      end
      i_req = '0;
      checkOutput("tbl_grant", 32'(firstGrant), 32'(tbl[v].expGrant));
      checkOutput("tbl_beats", 32'(beats),      32'(tbl[v].expBeats));
      checkOutput("tbl_done",  32'(doneSeen),   32'(tbl[v].expGrant));
    end

    // After consumer 1 finishes, the pointer sits at 2: 1 and 3 requesting picks 3.
    doReset();
    pushWords(10);
    i_len = {NREQ{4'd4}}; i_rd_ready = '1; i_req = 4'b0010;
    clearObs();
    for (int c = 0; c < 5; c++) applyStimulus();
    checkOutput("single_done", 32'(doneSeen), 32'(4'b0010));
    checkOutput("single_data3", 32'(gotData.size() == 4 ? gotData[3] : 8'hFF), 32'(8'd3));
    i_req = 4'b1010;
    applyStimulus();
    applyStimulus();
    checkOutput("ptr_after_g1", 32'(lastGrant), 32'(4'b1000));

    // Everyone requesting two words: 0,1,2,3,0 with one idle cycle between grants.
    doReset();
    pushWords(20);
    i_len = {NREQ{4'd2}}; i_rd_ready = '1; i_req = 4'hF;
    clearObs();
    for (int c = 0; c < 15; c++) begin
      applyStimulus();
      expG = (c % 3 == 0) ? 4'b0000 : (4'b0001 << ((c / 3) % 4));
      checkOutput("rr_grant", 32'(lastGrant), 32'(expG));
    end
    checkOutput("rr_beats", 32'(beats), 32'(10));

    // Empty stall: two words, grant held while empty, then two more arrive.
    doReset();
    pushWords(2);
    i_len = {NREQ{4'd4}}; i_rd_ready = '1; i_req = 4'b0001;
    clearObs();
    for (int c = 0; c < 3; c++) applyStimulus();
    for (int c = 0; c < 3; c++) begin
      applyStimulus();
      checkOutput("stall_r_en",  32'(lastREn),   32'(0));
      checkOutput("stall_grant", 32'(lastGrant), 32'(4'b0001));
    end
    checkOutput("stall_done_early", 32'(doneSeen), 32'(0));
    pushWords(2);
    for (int c = 0; c < 6 && doneSeen == '0; c++) applyStimulus();
    checkOutput("stall_beats", 32'(beats),    32'(4));
    checkOutput("stall_done",  32'(doneSeen), 32'(4'b0001));

    // Backpressure on consumer 2; other ready bits stay high and must not matter.
    doReset();
    pushWords(5);
    i_len = {NREQ{4'd3}}; i_rd_ready = '1; i_req = 4'b0100;
    clearObs();
    applyStimulus();
    for (int c = 0; c < 5; c++) begin
      i_rd_ready = (c == 1 || c == 2) ? 4'b1011 : 4'b1111;
      applyStimulus();
      checkOutput("bp_r_en", 32'(lastREn), 32'((c == 1 || c == 2) ? 0 : 1));
    end
    checkOutput("bp_beats", 32'(beats), 32'(3));
    checkOutput("bp_done",  32'(doneSeen), 32'(4'b0100));
    for (int i = 0; i < 3; i++)
      checkOutput("bp_data", 32'(gotData.size() > i ? gotData[i] : 8'hFF), 32'(i));

    // Abort after two of six words, then consumer 3 takes over.
    doReset();
    pushWords(10);
    i_len = {NREQ{4'd6}}; i_rd_ready = '1; i_req = 4'b1001;
    clearObs();
    for (int c = 0; c < 3; c++) applyStimulus();
    i_req = 4'b1000;
    applyStimulus();
    checkOutput("abort_r_en",  32'(lastREn),  32'(0));
    checkOutput("abort_beats", 32'(beats),    32'(2));
    checkOutput("abort_done",  32'(doneSeen), 32'(4'b0001));
    applyStimulus();
    applyStimulus();
    checkOutput("abort_next", 32'(lastGrant), 32'(4'b1000));

    // Reset in the middle of a burst, then requests from 2 and 0 with len 0.
    doReset();
    pushWords(10);
    i_len = {NREQ{4'd6}}; i_rd_ready = '1; i_req = 4'b0100;
    clearObs();
    for (int c = 0; c < 4; c++) applyStimulus();
    checkOutput("mid_beats", 32'(beats), 32'(3));
    #2;
    doReset();
    pushWords(10);
    i_len = '0; i_rd_ready = '1; i_req = 4'b0101;
    clearObs();
    applyStimulus();
    applyStimulus();
    checkOutput("post_rst_grant", 32'(lastGrant), 32'(4'b0001));
    for (int c = 0; c < 20 && doneSeen == '0; c++) applyStimulus();
    checkOutput("post_rst_beats", 32'(beats),    32'(8));
    checkOutput("post_rst_done",  32'(doneSeen), 32'(4'b0001));

    // Randomized traffic against the model.
    doReset();
    clearObs();
    for (int c = 0; c < 800; c++) begin
      if ($urandom_range(0, 7) == 0) i_req = NREQ'($urandom);
      i_len      = LENW'($urandom);
      i_rd_ready = NREQ'($urandom | $urandom);
      if ($urandom_range(0, 1) == 1 && fifoQ.size() < 16) pushWords(1);
      applyStimulus();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
